// File: rtl/video_pattern_source_if.sv
// rtl/video_pattern_source_if.sv - pixel stream interface between the pattern source and its sink
//
// Signals:
//   valid  source -> sink  pixel valid
//   ready  sink -> source  sink can accept the presented pixel
//   red    source -> sink  8-bit red component
//   green  source -> sink  8-bit green component
//   blue   source -> sink  8-bit blue component
//   last   source -> sink  final pixel of the frame
interface video_pattern_source_if;
    logic       valid;
    logic       ready;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       last;

    modport master (
        output valid,
        output red,
        output green,
        output blue,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  red,
        input  green,
        input  blue,
        input  last,
        output ready
    );
endinterface

// File: rtl/video_pattern_source.sv
// rtl/video_pattern_source.sv - one-frame RGB888 test pattern generator on a valid/ready pixel stream
//
// Ports:
//   clock_i       system clock, rising edge
//   reset_i       asynchronous active-high reset
//   start_i       request one frame (sampled in IDLE only)
//   pattern_i     pattern select, latched at frame start
//                 0 colour bars, 1 gradient, 2 checkerboard, 3 solid frame_count
//   master        pixel stream (valid/ready/red/green/blue/last)
//   busy_o        high while a frame is being streamed
//   frame_done_o  one-cycle pulse after the final pixel is accepted
module video_pattern_source #(
    parameter int Height = 480,
    parameter int Width  = 640
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [1:0]                    pattern_i,
    video_pattern_source_if.master        master,
    output logic                          busy_o,
    output logic                          frame_done_o
);

    // A single-row frame still needs a one-bit row counter.
    localparam int RW = (Height > 1) ? $clog2(Height) : 1;
    localparam int CW = $clog2(Width);

    localparam logic [RW-1:0] ROW_LAST = RW'(Height - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(Width - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    pattern_q, pattern_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [23:0]   pixel_q, pixel_d;
    logic          done_q, done_d;

    logic          handshake;
    logic          at_last;
    logic [RW-1:0] next_row;
    logic [CW-1:0] next_col;

    // Pixel colour for a coordinate. Row/column are taken mod 256 where
    // a byte is needed; the bar index uses the full column value.
    function automatic logic [23:0] pixel_f(
        input logic [RW-1:0] row,
        input logic [CW-1:0] col,
        input logic [1:0]    pattern,
        input logic [7:0]    frame_count
    );
        logic [2:0]  bar;
        logic [7:0]  row8;
        logic [7:0]  col8;
        logic        check;
        logic [23:0] rgb;
        bar   = 3'((32'(col) * 32'd8) / 32'(Width));
        row8  = 8'(row);
        col8  = 8'(col);
        check = 1'(32'(row) >> 3) ^ 1'(32'(col) >> 3);
        rgb   = 24'h000000;
        case (pattern)
            2'd0: begin
                case (bar)
                    3'd0:    rgb = 24'hFFFFFF;
                    3'd1:    rgb = 24'hFFFF00;
                    3'd2:    rgb = 24'h00FFFF;
                    3'd3:    rgb = 24'h00FF00;
                    3'd4:    rgb = 24'hFF00FF;
                    3'd5:    rgb = 24'hFF0000;
                    3'd6:    rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            2'd1:    rgb = {col8, row8, 8'(row8 + col8)};
            2'd2:    rgb = check ? 24'hFFFFFF : 24'h000000;
            default: rgb = {frame_count, frame_count, frame_count};
        endcase
        return rgb;
    endfunction

    assign handshake = valid_q && master.ready;
    assign at_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        next_row = row_q;
        next_col = col_q + CW'(1);
        if (col_q == COL_LAST) begin
            next_col = '0;
            next_row = row_q + RW'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        pattern_d     = pattern_q;
        frame_count_d = frame_count_q;
        valid_d       = valid_q;
        last_d        = last_q;
        pixel_d       = pixel_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pattern_d = pattern_i;
                    row_d     = '0;
                    col_d     = '0;
                    pixel_d   = pixel_f('0, '0, pattern_i, frame_count_q);
                    valid_d   = 1'b1;
                    // Width is at least 8, so pixel (0,0) is never the last one.
                    last_d    = 1'b0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                // Without a handshake every output register holds, which
                // keeps data and last stable during back-pressure.
                if (handshake) begin
                    if (at_last) begin
                        valid_d       = 1'b0;
                        last_d        = 1'b0;
                        done_d        = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                        state_d       = IDLE;
                    end else begin
                        row_d   = next_row;
                        col_d   = next_col;
                        pixel_d = pixel_f(next_row, next_col, pattern_q, frame_count_q);
                        last_d  = (next_row == ROW_LAST) && (next_col == COL_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            pattern_q     <= '0;
            frame_count_q <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            pixel_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            pattern_q     <= pattern_d;
            frame_count_q <= frame_count_d;
            valid_q       <= valid_d;
            last_q        <= last_d;
            pixel_q       <= pixel_d;
            done_q        <= done_d;
        end
    end

    assign master.valid = valid_q;
    assign master.last  = last_q;
    assign master.red   = pixel_q[23:16];
    assign master.green = pixel_q[15:8];
    assign master.blue  = pixel_q[7:0];
    assign busy_o       = (state_q == STREAM);
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// tb/tb_video_pattern_source.sv - scoreboard bench for video_pattern_source
module tb_video_pattern_source;
    localparam int H = 4;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] pattern;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    video_pattern_source_if vif();

    video_pattern_source #(.Height(H), .Width(W)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .start_i      (start),
        .pattern_i    (pattern),
        .master       (vif),
        .busy_o       (busy),
        .frame_done_o (done)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_cur;
    beat_t mon_exp;
    beat_t held;
    int    checks   = 0;
    int    passes   = 0;
    int    hs_count = 0;
    bit    done_pending  = 1'b0;
    bit    stall_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [23:0] model(input int p, input int r, input int c, input int fc);
        logic [23:0] rgb;
        case (p)
            0: begin
                case ((c * 8) / W)
                    0:       rgb = 24'hFFFFFF;
                    1:       rgb = 24'hFFFF00;
                    2:       rgb = 24'h00FFFF;
                    3:       rgb = 24'h00FF00;
                    4:       rgb = 24'hFF00FF;
                    5:       rgb = 24'hFF0000;
                    6:       rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            1:       rgb = {8'(c), 8'(r), 8'(r + c)};
            2:       rgb = ((((r >> 3) ^ (c >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: rgb = {8'(fc), 8'(fc), 8'(fc)};
        endcase
        return rgb;
    endfunction

    task automatic push_frame(input int p, input int fc);
        beat_t b;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                b.rgb  = model(p, r, c, fc);
                b.last = (r == H - 1) && (c == W - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Monitor: pops the expected beat on every handshake, watches stalls and the done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            mon_cur = {vif.red, vif.green, vif.blue, vif.last};
            if (stall_pending) begin
                chk("stall_hold", 32'(mon_cur), 32'(held));
                chk("stall_valid", 32'(vif.valid), 32'd1);
            end
            stall_pending = vif.valid && !vif.ready;
            held = mon_cur;
            if (done_pending) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_valid", 32'(vif.valid), 32'd0);
                done_pending = 1'b0;
            end else if (done) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end
            if (vif.valid && vif.ready) begin
                hs_count++;
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("beat", 32'(mon_cur), 32'(mon_exp));
                end
                if (vif.last) done_pending = 1'b1;
            end
        end
    end

    task automatic start_frame(input logic [1:0] p);
        @(posedge clk); #1;
        start   = 1'b1;
        pattern = p;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_frame_end(input string name);
        int n = 0;
        while ((busy || done_pending || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_timeout"}, 32'(n < 2000), 32'd1);
        chk({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        done_pending  = 1'b0;
        stall_pending = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int zeros;
        rst       = 1'b1;
        start     = 1'b0;
        pattern   = 2'd0;
        vif.ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(vif.valid), 32'd0);
        chk("rst_last", 32'(vif.last), 32'd0);
        chk("rst_rgb", {8'd0, vif.red, vif.green, vif.blue}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_valid", 32'(vif.valid), 32'd0);

        // Gradient, ready held high
        vif.ready = 1'b1;
        hs_count  = 0;
        push_frame(1, 0);
        start_frame(2'd1);
        wait_frame_end("grad");
        chk("grad_beats", 32'(hs_count), 32'd64);

        // Colour bars
        hs_count = 0;
        push_frame(0, 1);
        start_frame(2'd0);
        wait_frame_end("bars");
        chk("bars_beats", 32'(hs_count), 32'd64);

        // Checkerboard with random back-pressure
        hs_count = 0;
        push_frame(2, 2);
        start_frame(2'd2);
        n = 0;
        while (busy && n < 2000) begin
            vif.ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        vif.ready = 1'b1;
        chk("checker_timeout", 32'(n < 2000), 32'd1);
        wait_frame_end("checker");
        chk("checker_beats", 32'(hs_count), 32'd64);

        // Held start, solid pattern, three frames after a reset
        pulse_reset();
        push_frame(3, 0);
        push_frame(3, 1);
        push_frame(3, 2);
        @(posedge clk); #1;
        start   = 1'b1;
        pattern = 2'd3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vif.valid && n < 10);
        chk("held_first_valid", 32'(vif.valid), 32'd1);
        zeros = 0;
        for (int idx = 1; idx < 194; idx++) begin
            @(negedge clk);
            if (!vif.valid) zeros++;
            if (idx == 10)  pattern = 2'd0;
            if (idx == 50)  pattern = 2'd3;
            if (idx == 80)  pattern = 2'd1;
            if (idx == 110) pattern = 2'd3;
            if (idx == 150) start = 1'b0;
        end
        chk("held_idle_gaps", 32'(zeros), 32'd2);
        wait_frame_end("held");

        // Reset at beat 20, then restart with cleared frame_count
        push_frame(3, 3);
        start_frame(2'd3);
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(vif.valid), 32'd0);
        chk("midrst_last", 32'(vif.last), 32'd0);
        chk("midrst_rgb", {8'd0, vif.red, vif.green, vif.blue}, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        done_pending  = 1'b0;
        stall_pending = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        hs_count = 0;
        push_frame(3, 0);
        start_frame(2'd3);
        wait_frame_end("after_rst");
        chk("after_rst_beats", 32'(hs_count), 32'd64);

        // Ready low while last is presented
        push_frame(1, 1);
        start_frame(2'd1);
        n = 0;
        while (!vif.last && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vif.ready = 1'b0;
        chk("last_seen", 32'(vif.last), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("last_hold", 32'(vif.last), 32'd1);
            chk("last_busy", 32'(busy), 32'd1);
            chk("last_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        vif.ready = 1'b1;
        wait_frame_end("last_stall");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
